// File: rtl/fetch_pc_gen_pkg.sv
// Shared types for the fetch PC generator: the fetch-block entry held in the
// output queue and the "no branch" ID value.
package fetch_pc_gen_pkg;

    localparam int MAX_SLOTS = 8;
    localparam int MAX_BID_W = 8;

    localparam logic [MAX_BID_W-1:0] NO_BRANCH = '1;

    // Sized for the largest configuration; narrower instances use the low slots/bits.
    typedef struct packed {
        logic [MAX_SLOTS-1:0][31:0]          pc;
        logic [MAX_SLOTS-1:0]                slot_valid;
        logic [MAX_SLOTS-1:0]                branch_pred;
        logic [MAX_SLOTS-1:0][MAX_BID_W-1:0] branch_id;
    } fetch_block_t;

    localparam fetch_block_t EMPTY_BLOCK = '{
        pc:          '0,
        slot_valid:  '0,
        branch_pred: '0,
        branch_id:   {MAX_SLOTS{NO_BRANCH}}
    };

    function automatic logic [31:0] slot_pc(input logic [31:0] base, input int idx);
        return base + 32'(4 * idx);
    endfunction

endpackage

// File: rtl/fetch_block_fifo.sv
// Two-entry FIFO of fetch blocks; the head is presented combinationally and a
// flush empties it on the next edge regardless of push/pop.
module fetch_block_fifo
    import fetch_pc_gen_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_block_t entry_i,
    output fetch_block_t head_o,
    output logic         valid_o,
    output logic         full_o
);

    fetch_block_t mem_q [2];
    logic [1:0]   count_q, count_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr;

    // With two entries and a simultaneous pop, the write lands in the slot being vacated.
    assign wr_ptr = rd_ptr_q ^ count_q[0];

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
        end else begin
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= EMPTY_BLOCK;
            end
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_i && !flush_i) begin
                mem_q[wr_ptr] <= entry_i;
            end
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : EMPTY_BLOCK;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: builds one fetch block per issue from the current PC and
// the same-cycle predictor result, and queues blocks for decode.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int          NUM_SLOTS = 4,
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int          BID_W     = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       IN_redirValid,
    input  logic [31:0]                IN_redirPc,
    input  logic                       IN_BP_branchFound,
    input  logic                       IN_BP_branchTaken,
    input  logic                       IN_BP_isJump,
    input  logic                       IN_BP_multipleBranches,
    input  logic [31:0]                IN_BP_branchSrc,
    input  logic [31:0]                IN_BP_branchDst,
    input  logic [BID_W-1:0]           IN_BP_branchID,
    input  logic                       IN_ready,
    output logic [31:0]                OUT_pcRaw,
    output logic                       OUT_valid,
    output logic [NUM_SLOTS*32-1:0]    OUT_pc,
    output logic [NUM_SLOTS-1:0]       OUT_slotValid,
    output logic [NUM_SLOTS-1:0]       OUT_branchPred,
    output logic [NUM_SLOTS*BID_W-1:0] OUT_branchID,
    input  logic [31:0]                IN_instrMappingBase,
    input  logic                       IN_instrMappingHalfSize,
    output logic                       OUT_instrMappingMiss
);

    localparam int SW = $clog2(NUM_SLOTS);

    logic [31:1]  pc_q, pc_d;
    logic [31:0]  base, next_pc;
    logic [SW-1:0] s0, b;
    logic         br_hit, br_take, br_stop;
    logic         fifo_valid, fifo_full, pop, issue;
    fetch_block_t blk, head;

    assign OUT_pcRaw = {pc_q, 1'b0};
    assign base      = {pc_q[31:SW+2], {(SW+2){1'b0}}};
    assign s0        = pc_q[SW+1:2];
    assign b         = IN_BP_branchSrc[SW+1:2];

    // A predicted branch before the start slot belongs to an earlier entry point; drop it.
    assign br_hit  = IN_BP_branchFound && (b >= s0);
    assign br_take = br_hit && (IN_BP_branchTaken || IN_BP_isJump);
    assign br_stop = br_take || (br_hit && IN_BP_multipleBranches);

    assign pop   = fifo_valid && IN_ready;
    assign issue = !IN_redirValid && (!fifo_full || pop);

    always_comb begin
        blk = EMPTY_BLOCK;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            blk.pc[i]         = slot_pc(base, i);
            blk.slot_valid[i] = (i >= int'(s0)) && (!br_stop || i <= int'(b));
            if (br_hit && i == int'(b)) begin
                blk.branch_id[i]   = MAX_BID_W'(IN_BP_branchID);
                blk.branch_pred[i] = br_take;
            end
        end
    end

    always_comb begin
        if (br_take) begin
            next_pc = {IN_BP_branchDst[31:1], 1'b0};
        end else if (br_stop) begin
            next_pc = IN_BP_branchSrc + 32'd4;
        end else begin
            next_pc = base + 32'(4 * NUM_SLOTS);
        end

        if (IN_redirValid) begin
            pc_d = IN_redirPc[31:1];
        end else if (issue) begin
            pc_d = next_pc[31:1];
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC[31:1];
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_block_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (IN_redirValid),
        .push_i  (issue),
        .pop_i   (pop),
        .entry_i (blk),
        .head_o  (head),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

    assign OUT_valid = fifo_valid;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign OUT_pc[gi*32 +: 32]          = head.pc[gi];
        assign OUT_slotValid[gi]            = head.slot_valid[gi];
        assign OUT_branchPred[gi]           = head.branch_pred[gi];
        assign OUT_branchID[gi*BID_W +: BID_W] = head.branch_id[gi][BID_W-1:0];
    end

    assign OUT_instrMappingMiss = (OUT_pcRaw[31:13] != IN_instrMappingBase[31:13]) ||
                                  (IN_instrMappingHalfSize && (OUT_pcRaw[12] != IN_instrMappingBase[12]));

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with a scoreboard of expected fetch blocks.
module tb_fetch_pc_gen;

    localparam int          NS     = 4;
    localparam int          BW     = 6;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              redir_valid;
    logic [31:0]       redir_pc;
    logic              bp_found, bp_taken, bp_jump, bp_mult;
    logic [31:0]       bp_src, bp_dst;
    logic [BW-1:0]     bp_id;
    logic              ready;
    logic [31:0]       map_base;
    logic              map_half;
    logic [31:0]       out_pc_raw;
    logic              out_valid;
    logic [NS*32-1:0]  out_pc;
    logic [NS-1:0]     out_slot_valid, out_branch_pred;
    logic [NS*BW-1:0]  out_branch_id;
    logic              out_map_miss;

    typedef struct {
        logic [NS*32-1:0] pc;
        logic [NS-1:0]    sv;
        logic [NS-1:0]    pred;
        logic [NS*BW-1:0] id;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    int          vectors = 0;
    int          miscompares = 0;

    fetch_pc_gen #(.NUM_SLOTS(NS), .RESET_PC(RST_PC), .BID_W(BW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .IN_redirValid           (redir_valid),
        .IN_redirPc              (redir_pc),
        .IN_BP_branchFound       (bp_found),
        .IN_BP_branchTaken       (bp_taken),
        .IN_BP_isJump            (bp_jump),
        .IN_BP_multipleBranches  (bp_mult),
        .IN_BP_branchSrc         (bp_src),
        .IN_BP_branchDst         (bp_dst),
        .IN_BP_branchID          (bp_id),
        .IN_ready                (ready),
        .OUT_pcRaw               (out_pc_raw),
        .OUT_valid               (out_valid),
        .OUT_pc                  (out_pc),
        .OUT_slotValid           (out_slot_valid),
        .OUT_branchPred          (out_branch_pred),
        .OUT_branchID            (out_branch_id),
        .IN_instrMappingBase     (map_base),
        .IN_instrMappingHalfSize (map_half),
        .OUT_instrMappingMiss    (out_map_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected block and follow-on PC for the current model PC and predictor inputs.
    task automatic predict(output exp_t e, output logic [31:0] nxt);
        logic [31:0] base;
        int s0, bslot, last;
        bit hit;
        base  = {m_pc[31:4], 4'b0000};
        s0    = int'(m_pc[3:2]);
        bslot = int'(bp_src[3:2]);
        hit   = bp_found && (bslot >= s0);
        e.id   = '1;
        e.pred = '0;
        nxt    = base + 32'd16;
        last   = NS - 1;
        for (int i = 0; i < NS; i++) e.pc[i*32 +: 32] = base + 32'(4 * i);
        if (hit) begin
            e.id[bslot*BW +: BW] = bp_id;
            if (bp_taken || bp_jump) begin
                e.pred[bslot] = 1'b1;
                last = bslot;
                nxt  = bp_dst & ~32'd1;
            end else if (bp_mult) begin
                last = bslot;
                nxt  = bp_src + 32'd4;
            end
        end
        for (int i = 0; i < NS; i++) e.sv[i] = (i >= s0) && (i <= last);
    endtask

    task automatic check_outputs();
        chk("pcRaw", 128'(out_pc_raw), 128'(m_pc));
        chk("valid", 128'(out_valid), 128'(sb.size() > 0));
        if (sb.size() > 0) begin
            chk("slotValid", 128'(out_slot_valid), 128'(sb[0].sv));
            chk("pc", 128'(out_pc), 128'(sb[0].pc));
            chk("branchPred", 128'(out_branch_pred), 128'(sb[0].pred));
            chk("branchID", 128'(out_branch_id), 128'(sb[0].id));
        end
    endtask

    task automatic step();
        exp_t e;
        logic [31:0] nxt;
        bit pop_m, issue_m;
        pop_m   = (sb.size() > 0) && ready;
        issue_m = !redir_valid && ((sb.size() < 2) || pop_m);
        predict(e, nxt);
        @(posedge clk);
        #1;
        if (redir_valid) begin
            sb.delete();
            m_pc = redir_pc & ~32'd1;
        end else begin
            if (pop_m) void'(sb.pop_front());
            if (issue_m) begin
                sb.push_back(e);
                m_pc = nxt;
            end
        end
        $display("step t=%0t pcRaw=%h valid=%b slotValid=%b pred=%b id=%h head_pc0=%h",
                 $time, out_pc_raw, out_valid, out_slot_valid, out_branch_pred, out_branch_id, out_pc[31:0]);
        check_outputs();
    endtask

    task automatic clear_bp();
        bp_found = 0; bp_taken = 0; bp_jump = 0; bp_mult = 0;
        bp_src = '0; bp_dst = '0; bp_id = '0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redir_valid = 1'b1;
        redir_pc    = target;
        step();
        redir_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; redir_valid = 0; redir_pc = '0; ready = 0;
        map_base = 32'h8000_0000; map_half = 1'b1;
        clear_bp();
        m_pc = RST_PC;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_slotValid", 128'(out_slot_valid), 128'(0));
        chk("rst_branchPred", 128'(out_branch_pred), 128'(0));
        chk("rst_branchID", 128'(out_branch_id), 128'(24'hFF_FFFF));
        chk("rst_pc", 128'(out_pc), 128'(0));
        chk("rst_pcRaw", 128'(out_pc_raw), 128'(RST_PC));
        chk("rst_mapMiss", 128'(out_map_miss), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Sequential blocks, one per cycle
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("seq_pc0", 128'(out_pc[31:0]), 128'(RST_PC + 32'(16 * k)));
            chk("seq_slotValid", 128'(out_slot_valid), 128'(4'b1111));
        end

        // Redirect into mid-block
        redirect(32'h8000_0108);
        chk("redir_flush", 128'(out_valid), 128'(0));
        step();
        chk("redir_slotValid", 128'(out_slot_valid), 128'(4'b1100));
        chk("redir_pc2", 128'(out_pc[95:64]), 128'(32'h8000_0108));

        // Taken branch
        redirect(32'h8000_0000);
        bp_found = 1; bp_taken = 1; bp_src = 32'h8000_0004; bp_dst = 32'h8000_0200; bp_id = 6'd5;
        step();
        clear_bp();
        chk("taken_slotValid", 128'(out_slot_valid), 128'(4'b0011));
        chk("taken_pred", 128'(out_branch_pred), 128'(4'b0010));
        chk("taken_id1", 128'(out_branch_id[11:6]), 128'(6'd5));
        step();
        chk("taken_target", 128'(out_pc[31:0]), 128'(32'h8000_0200));

        // Not-taken with multiple branches
        redirect(32'h8000_0000);
        bp_found = 1; bp_mult = 1; bp_src = 32'h8000_0008; bp_id = 6'd7;
        step();
        clear_bp();
        chk("mult_slotValid", 128'(out_slot_valid), 128'(4'b0111));
        chk("mult_pred", 128'(out_branch_pred), 128'(4'b0000));
        chk("mult_id2", 128'(out_branch_id[17:12]), 128'(6'd7));
        chk("mult_nextpc", 128'(out_pc_raw), 128'(32'h8000_000C));

        // Back-pressure: queue fills to two, PC holds
        ready = 1'b0;
        repeat (4) step();
        chk("full_pcHeld", 128'(out_pc_raw), 128'(32'h8000_0010));
        redirect(32'h8000_0008);
        chk("full_redir_flush", 128'(out_valid), 128'(0));

        // Branch before the start slot is ignored
        ready = 1'b1;
        bp_found = 1; bp_taken = 1; bp_src = 32'h8000_0004; bp_dst = 32'h8000_0300; bp_id = 6'd3;
        step();
        clear_bp();
        chk("early_br_slotValid", 128'(out_slot_valid), 128'(4'b1100));
        chk("early_br_nextpc", 128'(out_pc_raw), 128'(32'h8000_0010));

        // Single not-taken branch
        bp_found = 1; bp_src = 32'h8000_001C; bp_id = 6'd9;
        step();
        clear_bp();
        chk("single_slotValid", 128'(out_slot_valid), 128'(4'b1111));
        chk("single_id3", 128'(out_branch_id[23:18]), 128'(6'd9));
        chk("single_nextpc", 128'(out_pc_raw), 128'(32'h8000_0020));

        // Wrap-around and mapping window
        redirect(32'hFFFF_FFF8);
        step();
        chk("wrap_pcRaw", 128'(out_pc_raw), 128'(32'h0000_0000));
        chk("wrap_mapMiss", 128'(out_map_miss), 128'(1));
        redirect(32'h8000_1000);
        chk("half_mapMiss", 128'(out_map_miss), 128'(1));
        map_half = 1'b0;
        #1;
        chk("full_window_mapMiss", 128'(out_map_miss), 128'(0));
        map_half = 1'b1;

        // Asynchronous reset with two blocks queued
        redirect(32'h8000_0040);
        ready = 1'b0;
        repeat (2) step();
        chk("prefill_valid", 128'(out_valid), 128'(1));
        #2 rst = 1'b1;
        #1;
        sb.delete();
        m_pc = RST_PC;
        chk("async_rst_valid", 128'(out_valid), 128'(0));
        chk("async_rst_pcRaw", 128'(out_pc_raw), 128'(RST_PC));
        #1 rst = 1'b0;
        ready = 1'b1;
        step();
        chk("post_rst_pc0", 128'(out_pc[31:0]), 128'(RST_PC));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
